// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg
//   Shared definitions for the stopwatch controller: state encoding,
//   BCD digit limits and the 4-digit BCD increment used by the live count.
//   Digit layout of a 16-bit count: [15:12] seconds tens, [11:8] seconds ones,
//   [7:4] hundredths tens, [3:0] hundredths ones.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // 59.99 rolls over to 00.00 silently.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != DIGIT_MAX) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != DIGIT_MAX) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != DIGIT_MAX) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (v[15:12] != TENS_MAX) r[15:12] = v[15:12] + 4'd1;
          else                      r[15:12] = 4'd0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// btn_debounce
//   Synchronises a raw asynchronous button, debounces it and emits a
//   one-cycle pulse on each accepted press.
// Ports
//   clk_slw  in   clock
//   reset    in   synchronous active-high reset
//   i_btn    in   raw button, active-high
//   o_press  out  one-cycle pulse on a debounced 0->1 transition
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_slw,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_level_q;
  logic          r_armed;
  logic [1:0]    r_warm;
  logic [CW-1:0] r_cnt;

  // r_warm masks the two cycles after reset in which r_sync1 still holds its
  // reset value. r_armed only rises once the button is genuinely seen
  // released, so a button held through reset never yields a press.
  always_ff @(posedge clk_slw) begin
    if (reset) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_armed   <= 1'b0;
      r_warm    <= 2'b00;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= i_btn;
      r_sync1   <= r_sync0;
      r_level_q <= r_level;
      r_warm    <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_level && !r_sync1) r_armed <= 1'b1;
      if (r_sync1 != r_level) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_cnt   <= '0;
          r_level <= r_sync1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_armed && r_level && !r_level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Start/stop/lap stopwatch with 0.01 s resolution and a 00.00-59.99 range.
//
//   state | meaning
//   IDLE  | cleared, waiting for start
//   RUN   | counting, display shows live count
//   LAP   | counting, display frozen on lap register
//   STOP  | paused, prescaler and count held
//
// Ports
//   clk_slw     in   clock
//   reset       in   synchronous active-high reset
//   btn_ss      in   raw start/stop button
//   btn_lr      in   raw lap/clear button
//   num_1..4    out  BCD digits: sec tens, sec ones, 1/10 s, 1/100 s
//   paused      out  registered "state is STOP"
//   lap_active  out  registered "state is LAP"
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk_slw,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic [3:0] num_1,
  output logic [3:0] num_2,
  output logic [3:0] num_3,
  output logic [3:0] num_4,
  output logic       paused,
  output logic       lap_active
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_ss_p;
  logic          w_lr_p;
  logic          w_counting;
  logic          w_lap_cap;
  logic          w_clear;
  logic          w_tick;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_live;
  logic [15:0]   r_lap;
  logic [15:0]   r_disp;
  logic          r_paused;
  logic          r_lap_act;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk_slw (clk_slw),
    .reset   (reset),
    .i_btn   (btn_ss),
    .o_press (w_ss_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
    .clk_slw (clk_slw),
    .reset   (reset),
    .i_btn   (btn_lr),
    .o_press (w_lr_p)
  );

  always_ff @(posedge clk_slw) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ss_p always has priority; lr_p is dropped when both arrive together.
  always_comb begin
    w_state_nxt = r_state;
    w_counting  = 1'b0;
    w_lap_cap   = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ss_p) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_counting = 1'b1;
        if (w_ss_p) begin
          w_state_nxt = ST_STOP;
        end else if (w_lr_p) begin
          w_state_nxt = ST_LAP;
          w_lap_cap   = 1'b1;
        end
      end
      ST_LAP: begin
        w_counting = 1'b1;
        if (w_ss_p)      w_state_nxt = ST_STOP;
        else if (w_lr_p) w_state_nxt = ST_RUN;
      end
      ST_STOP: begin
        if (w_ss_p) begin
          w_state_nxt = ST_RUN;
        end else if (w_lr_p) begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_tick = w_counting && (r_presc == PW'(TICK_DIV - 1));

  // Lap capture reads r_live before this edge's increment lands.
  always_ff @(posedge clk_slw) begin
    if (reset) begin
      r_presc   <= '0;
      r_live    <= '0;
      r_lap     <= '0;
      r_disp    <= '0;
      r_paused  <= 1'b0;
      r_lap_act <= 1'b0;
    end else begin
      if (w_clear) begin
        r_presc <= '0;
        r_live  <= '0;
        r_lap   <= '0;
      end else begin
        if (w_counting) r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick)     r_live  <= bcd_inc(r_live);
        if (w_lap_cap)  r_lap   <= r_live;
      end
      r_disp    <= (r_state == ST_LAP) ? r_lap : r_live;
      r_paused  <= (r_state == ST_STOP);
      r_lap_act <= (r_state == ST_LAP);
    end
  end

  assign num_1      = r_disp[15:12];
  assign num_2      = r_disp[11:8];
  assign num_3      = r_disp[7:4];
  assign num_4      = r_disp[3:0];
  assign paused     = r_paused;
  assign lap_active = r_lap_act;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=3.
// Inputs change and outputs are sampled on the falling edge. Timing notes:
// a press started at the negedge after edge a is acted on at edge a+6;
// press(...,5,6) returns after edge a+11. In RUN, with t edges since the
// start transition, live = t/4 and the display shows (t-1)/4.
module tb_stopwatch_ctrl;

  logic       clk_slw = 1'b0;
  logic       reset   = 1'b1;
  logic       btn_ss  = 1'b0;
  logic       btn_lr  = 1'b0;
  logic [3:0] num_1, num_2, num_3, num_4;
  logic       paused, lap_active;
  logic [15:0] disp;
  int n_cmp = 0;
  int n_err = 0;

  assign disp = {num_1, num_2, num_3, num_4};

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk_slw    (clk_slw),
    .reset      (reset),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .num_1      (num_1),
    .num_2      (num_2),
    .num_3      (num_3),
    .num_4      (num_4),
    .paused     (paused),
    .lap_active (lap_active)
  );

  always #5 clk_slw = ~clk_slw;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_slw);
  endtask

  task automatic do_reset();
    @(negedge clk_slw);
    reset = 1'b1;
    @(negedge clk_slw);
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic press(input logic ss, input logic lr, input int hold, input int post);
    btn_ss = ss;
    btn_lr = lr;
    wait_cyc(hold);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    wait_cyc(post);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(3);
    n_cmp++; if (disp !== 16'h0000) begin n_err++; $display("FAIL reset_disp: got %h want %h", disp, 16'h0000); end
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL reset_paused: got %b want 0", paused); end
    n_cmp++; if (lap_active !== 1'b0) begin n_err++; $display("FAIL reset_lap: got %b want 0", lap_active); end
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_start();
    do_reset();
    press(1'b1, 1'b0, 5, 6);
    n_cmp++; if (disp !== 16'h0001) begin n_err++; $display("FAIL start_disp_t5: got %h want %h", disp, 16'h0001); end
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL start_paused: got %b want 0", paused); end
    wait_cyc(36);
    n_cmp++; if (disp !== 16'h0010) begin n_err++; $display("FAIL start_disp_t41: got %h want %h", disp, 16'h0010); end
  endtask

  task automatic test_wrap();
    do_reset();
    press(1'b1, 1'b0, 5, 6);
    wait_cyc(23995);
    n_cmp++; if (disp !== 16'h5999) begin n_err++; $display("FAIL wrap_pre: got %h want %h", disp, 16'h5999); end
    wait_cyc(1);
    n_cmp++; if (disp !== 16'h0000) begin n_err++; $display("FAIL wrap_post: got %h want %h", disp, 16'h0000); end
    n_cmp++; if (num_1 !== 4'd0) begin n_err++; $display("FAIL wrap_num1: got %0d want 0", num_1); end
  endtask

  task automatic test_lap();
    do_reset();
    press(1'b1, 1'b0, 5, 6);
    wait_cyc(10);
    press(1'b0, 1'b1, 5, 6);
    n_cmp++; if (lap_active !== 1'b1) begin n_err++; $display("FAIL lap_active_on: got %b want 1", lap_active); end
    n_cmp++; if (disp !== 16'h0005) begin n_err++; $display("FAIL lap_frozen_t26: got %h want %h", disp, 16'h0005); end
    wait_cyc(14);
    n_cmp++; if (disp !== 16'h0005) begin n_err++; $display("FAIL lap_frozen_t40: got %h want %h", disp, 16'h0005); end
    press(1'b0, 1'b1, 5, 6);
    n_cmp++; if (lap_active !== 1'b0) begin n_err++; $display("FAIL lap_active_off: got %b want 0", lap_active); end
    n_cmp++; if (disp !== 16'h0012) begin n_err++; $display("FAIL lap_live_back: got %h want %h", disp, 16'h0012); end
  endtask

  task automatic test_pause();
    do_reset();
    press(1'b1, 1'b0, 5, 6);
    wait_cyc(18);
    press(1'b1, 1'b0, 5, 6);
    n_cmp++; if (paused !== 1'b1) begin n_err++; $display("FAIL pause_on: got %b want 1", paused); end
    n_cmp++; if (disp !== 16'h0007) begin n_err++; $display("FAIL pause_disp: got %h want %h", disp, 16'h0007); end
    wait_cyc(100);
    n_cmp++; if (disp !== 16'h0007) begin n_err++; $display("FAIL pause_hold: got %h want %h", disp, 16'h0007); end
    press(1'b1, 1'b0, 5, 6);
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL resume_paused: got %b want 0", paused); end
    n_cmp++; if (disp !== 16'h0008) begin n_err++; $display("FAIL resume_disp: got %h want %h", disp, 16'h0008); end
    wait_cyc(3);
    n_cmp++; if (disp !== 16'h0009) begin n_err++; $display("FAIL resume_phase: got %h want %h", disp, 16'h0009); end
    press(1'b1, 1'b0, 5, 6);
    n_cmp++; if (disp !== 16'h0010) begin n_err++; $display("FAIL stop2_disp: got %h want %h", disp, 16'h0010); end
    press(1'b0, 1'b1, 5, 6);
    n_cmp++; if (disp !== 16'h0000) begin n_err++; $display("FAIL clear_disp: got %h want %h", disp, 16'h0000); end
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL clear_paused: got %b want 0", paused); end
    press(1'b0, 1'b1, 5, 6);
    n_cmp++; if (disp !== 16'h0000 || lap_active !== 1'b0) begin n_err++; $display("FAIL idle_lr_ignored: got %h/%b want 0000/0", disp, lap_active); end
    press(1'b1, 1'b0, 5, 6);
    n_cmp++; if (disp !== 16'h0001) begin n_err++; $display("FAIL restart_disp: got %h want %h", disp, 16'h0001); end
    wait_cyc(2);
    n_cmp++; if (disp !== 16'h0001) begin n_err++; $display("FAIL restart_presc_clr: got %h want %h", disp, 16'h0001); end
  endtask

  task automatic test_glitch_both();
    do_reset();
    press(1'b1, 1'b0, 2, 6);
    wait_cyc(20);
    n_cmp++; if (disp !== 16'h0000 || paused !== 1'b0) begin n_err++; $display("FAIL glitch_ignored: got %h/%b want 0000/0", disp, paused); end
    press(1'b1, 1'b0, 30, 6);
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL hold_single_pulse: got %b want 0", paused); end
    n_cmp++; if (disp !== 16'h0007) begin n_err++; $display("FAIL hold_disp: got %h want %h", disp, 16'h0007); end
    press(1'b1, 1'b1, 5, 6);
    n_cmp++; if (paused !== 1'b1) begin n_err++; $display("FAIL both_paused: got %b want 1", paused); end
    n_cmp++; if (lap_active !== 1'b0) begin n_err++; $display("FAIL both_not_lap: got %b want 0", lap_active); end
    n_cmp++; if (disp !== 16'h0009) begin n_err++; $display("FAIL both_tick_applied: got %h want %h", disp, 16'h0009); end
  endtask

  task automatic test_reset_in_lap();
    do_reset();
    press(1'b1, 1'b0, 5, 6);
    wait_cyc(125);
    press(1'b0, 1'b1, 5, 6);
    n_cmp++; if (lap_active !== 1'b1) begin n_err++; $display("FAIL lap33_active: got %b want 1", lap_active); end
    n_cmp++; if (disp !== 16'h0033) begin n_err++; $display("FAIL lap33_pre_inc: got %h want %h", disp, 16'h0033); end
    reset = 1'b1;
    wait_cyc(1);
    n_cmp++; if (disp !== 16'h0000 || paused !== 1'b0 || lap_active !== 1'b0) begin n_err++; $display("FAIL lap_reset_outs: got %h/%b/%b want 0000/0/0", disp, paused, lap_active); end
    reset = 1'b0;
    wait_cyc(20);
    n_cmp++; if (disp !== 16'h0000 || lap_active !== 1'b0) begin n_err++; $display("FAIL lap_reset_idle: got %h/%b want 0000/0", disp, lap_active); end
  endtask

  task automatic test_held_through_reset();
    do_reset();
    press(1'b1, 1'b0, 5, 6);
    btn_ss = 1'b1;
    wait_cyc(10);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(20);
    n_cmp++; if (disp !== 16'h0000 || paused !== 1'b0) begin n_err++; $display("FAIL held_no_press: got %h/%b want 0000/0", disp, paused); end
    btn_ss = 1'b0;
    wait_cyc(6);
    press(1'b1, 1'b0, 5, 6);
    n_cmp++; if (disp !== 16'h0001) begin n_err++; $display("FAIL held_repress: got %h want %h", disp, 16'h0001); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_wrap();
    test_lap();
    test_pause();
    test_glitch_both();
    test_reset_in_lap();
    test_held_through_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
